// File: rtl/hazard_tag_pipe_if.sv
// Tag-chain bus between decode, the tag pipe and the hazard unit.
// Ports: Stall, D-stage tags in; E/M/W tags, PC/IF-ID/ID-EX controls, StallCnt out.
interface hazard_tag_pipe_if #(
    parameter int CNT_W = 16
);
    logic             Stall;
    logic [4:0]       A1D;
    logic [4:0]       A2D;
    logic [4:0]       A3D;
    logic [1:0]       resD;
    logic [4:0]       A1E;
    logic [4:0]       A2E;
    logic [4:0]       A3E;
    logic [1:0]       res_E;
    logic [4:0]       A3M;
    logic [1:0]       res_M;
    logic [4:0]       A3W;
    logic [1:0]       res_W;
    logic             PCEn;
    logic             IFIDEn;
    logic             IDEXClr;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output Stall, A1D, A2D, A3D, resD,
        input  A1E, A2E, A3E, res_E, A3M, res_M, A3W, res_W,
        input  PCEn, IFIDEn, IDEXClr, StallCnt
    );

    modport slave (
        input  Stall, A1D, A2D, A3D, resD,
        output A1E, A2E, A3E, res_E, A3M, res_M, A3W, res_W,
        output PCEn, IFIDEn, IDEXClr, StallCnt
    );
endinterface

// File: rtl/hazard_tag_pipe.sv
// Register-index / result-class tag chain D->E->M->W with stall controls.
// Ports: clk, reset (async, active-high), bus (slave side of hazard_tag_pipe_if).
module hazard_tag_pipe #(
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             reset,
    hazard_tag_pipe_if.slave bus
);
    logic [4:0]       a1_e;
    logic [4:0]       a2_e;
    logic [4:0]       a3_e;
    logic [1:0]       res_e;
    logic [4:0]       a3_m;
    logic [1:0]       res_m;
    logic [4:0]       a3_w;
    logic [1:0]       res_w;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       res_d_eff;

    // A write to $0 is never a real producer, so it must not look like one.
    assign res_d_eff = (bus.A3D == 5'd0) ? 2'b00 : bus.resD;

    assign bus.PCEn    = ~bus.Stall;
    assign bus.IFIDEn  = ~bus.Stall;
    assign bus.IDEXClr = bus.Stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a1_e  <= '0;
            a2_e  <= '0;
            a3_e  <= '0;
            res_e <= '0;
        end else if (bus.Stall) begin
            a1_e  <= '0;
            a2_e  <= '0;
            a3_e  <= '0;
            res_e <= '0;
        end else begin
            a1_e  <= bus.A1D;
            a2_e  <= bus.A2D;
            a3_e  <= bus.A3D;
            res_e <= res_d_eff;
        end
    end

    // M and W always advance: a stall only holds the front end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a3_m  <= '0;
            res_m <= '0;
            a3_w  <= '0;
            res_w <= '0;
        end else begin
            a3_m  <= a3_e;
            res_m <= res_e;
            a3_w  <= a3_m;
            res_w <= res_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (bus.Stall && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.A1E      = a1_e;
    assign bus.A2E      = a2_e;
    assign bus.A3E      = a3_e;
    assign bus.res_E    = res_e;
    assign bus.A3M      = a3_m;
    assign bus.res_M    = res_m;
    assign bus.A3W      = a3_w;
    assign bus.res_W    = res_w;
    assign bus.StallCnt = cnt;
endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed self-checking bench for hazard_tag_pipe (CNT_W = 3).
// Ports: none; drives the DUT through a hazard_tag_pipe_if master view.
module tb_hazard_tag_pipe;
    localparam int CW = 3;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    hazard_tag_pipe_if #(.CNT_W(CW)) bus ();

    hazard_tag_pipe #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input int a1, input int a2, input int a3,
                           input int r, input logic st);
        bus.A1D   = 5'(a1);
        bus.A2D   = 5'(a2);
        bus.A3D   = 5'(a3);
        bus.resD  = 2'(r);
        bus.Stall = st;
    endtask

    task automatic chk_e(input string tag, input int a1, input int a2,
                         input int a3, input int r);
        chk({tag, ".A1E"}, int'(bus.A1E), a1);
        chk({tag, ".A2E"}, int'(bus.A2E), a2);
        chk({tag, ".A3E"}, int'(bus.A3E), a3);
        chk({tag, ".res_E"}, int'(bus.res_E), r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_e(tag, 0, 0, 0, 0);
        chk({tag, ".A3M"}, int'(bus.A3M), 0);
        chk({tag, ".res_M"}, int'(bus.res_M), 0);
        chk({tag, ".A3W"}, int'(bus.A3W), 0);
        chk({tag, ".res_W"}, int'(bus.res_W), 0);
        chk({tag, ".StallCnt"}, int'(bus.StallCnt), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive_d(0, 0, 0, 0, 1'b0);
        #12;
        chk_all_zero("reset");
        chk("reset.PCEn", int'(bus.PCEn), 1);
        chk("reset.IDEXClr", int'(bus.IDEXClr), 0);
        reset = 1'b0;

        // Flow through E, M, W.
        drive_d(2, 3, 4, 1, 1'b0);
        tick();
        chk_e("flow1", 2, 3, 4, 1);
        tick();
        chk("flow2.A3M", int'(bus.A3M), 4);
        chk("flow2.res_M", int'(bus.res_M), 1);
        tick();
        chk("flow3.A3W", int'(bus.A3W), 4);
        chk("flow3.res_W", int'(bus.res_W), 1);
        chk("flow3.StallCnt", int'(bus.StallCnt), 0);

        // Load-use bubble.
        drive_d(1, 0, 5, 2, 1'b0);
        tick();
        chk_e("lw", 1, 0, 5, 2);
        bus.Stall = 1'b1;
        #1;
        chk("lu.PCEn", int'(bus.PCEn), 0);
        chk("lu.IFIDEn", int'(bus.IFIDEn), 0);
        chk("lu.IDEXClr", int'(bus.IDEXClr), 1);
        tick();
        chk_e("lu.bubble", 0, 0, 0, 0);
        chk("lu.A3M", int'(bus.A3M), 5);
        chk("lu.res_M", int'(bus.res_M), 2);
        chk("lu.StallCnt", int'(bus.StallCnt), 1);
        bus.Stall = 1'b0;
        #1;
        chk("lu.PCEn_after", int'(bus.PCEn), 1);

        // $0 sanitize, then a non-zero dest keeps class 11.
        drive_d(9, 10, 0, 1, 1'b0);
        tick();
        chk_e("zero", 9, 10, 0, 0);
        drive_d(1, 2, 31, 3, 1'b0);
        tick();
        chk_e("pc", 1, 2, 31, 3);

        // Fill pipe, then asynchronous reset between edges.
        drive_d(11, 12, 13, 1, 1'b0);
        tick();
        drive_d(14, 15, 16, 2, 1'b0);
        tick();
        drive_d(17, 18, 19, 3, 1'b0);
        tick();
        chk_e("full", 17, 18, 19, 3);
        chk("full.A3M", int'(bus.A3M), 16);
        chk("full.A3W", int'(bus.A3W), 13);
        chk("full.StallCnt", int'(bus.StallCnt), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async");
        reset = 1'b0;

        // Back-to-back stalls with D held.
        drive_d(6, 7, 8, 1, 1'b1);
        tick();
        chk_e("b2b1", 0, 0, 0, 0);
        tick();
        chk_e("b2b2", 0, 0, 0, 0);
        bus.Stall = 1'b0;
        tick();
        chk_e("b2b3", 6, 7, 8, 1);
        chk("b2b.StallCnt", int'(bus.StallCnt), 2);

        // Counter saturation at 7.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bus.Stall = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("sat%0d", i), int'(bus.StallCnt), (i < 7) ? i : 7);
        end

        // Stall and reset together: reset wins.
        reset = 1'b1;
        tick();
        chk("rst_stall.StallCnt", int'(bus.StallCnt), 0);
        chk_e("rst_stall", 0, 0, 0, 0);
        reset = 1'b0;
        bus.Stall = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_tag_pipe.md
Name: hazard_tag_pipe

Overview:
- Pipeline-tag register chain sitting between decode and the hazard detection unit.
- Carries source/destination register indices and the 2-bit result class from D through E, M and W, and produces the E/M/W tags the hazard unit compares against.
- Consumes the hazard unit's Stall: generates PC / IF-ID enables and the ID-EX bubble, and counts stall cycles for performance debug.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Stall  input  1  stall request from hazard unit (combinational, same cycle)
- A1D  input  5  rs index of instruction in D
- A2D  input  5  rt index of instruction in D
- A3D  input  5  destination index of instruction in D
- resD  input  2  result class in D: 00 NW, 01 ALU, 10 DM, 11 PC
- A1E  output  5  rs index in E
- A2E  output  5  rt index in E
- A3E  output  5  destination in E
- res_E  output  2  result class in E
- A3M  output  5  destination in M
- res_M  output  2  result class in M
- A3W  output  5  destination in W
- res_W  output  2  result class in W
- PCEn  output  1  PC write enable
- IFIDEn  output  1  IF/ID register enable
- IDEXClr  output  1  ID/EX bubble insert
- StallCnt  output  CNT_W  stall cycles since reset, saturating

Behaviour:
- Reset (asynchronous, active-high): takes effect immediately, independent of clk.
  - All A*E/M/W = 0, all res_* = 00, StallCnt = 0.
  - Reset asserted mid-stream discards all in-flight tags; first edge after deassertion loads normally.
- Combinational controls: PCEn = ~Stall, IFIDEn = ~Stall, IDEXClr = Stall. No register between Stall and these outputs.
- D-stage sanitize: if A3D == 0, the effective D result class is 00 (NW), whatever resD says. A write to $0 never appears as a producer. Otherwise the effective class is resD.
- Each rising clk edge:
  - E stage:
    - If Stall = 1: E loads a bubble (A1E = A2E = A3E = 0, res_E = 00).
    - Else: E loads A1D, A2D, A3D and the sanitized class.
  - M stage: M <= (A3E, res_E) unconditionally. Stall freezes only PC and IF/ID, never E→M→W.
  - W stage: W <= (A3M, res_M) unconditionally. W tags hold until the next edge; the tag leaves the chain after W.
- Latency: a tag presented in D with Stall = 0 appears at E after 1 edge, at M after 2 edges, at W after 3 edges.
- StallCnt: increments by 1 on each edge where Stall = 1. Saturates at 2^CNT_W − 1 and holds there (no wrap).
- Consecutive stalls: each stalled cycle inserts one bubble. The D instruction is re-presented by decode (IF/ID held) and enters E on the first edge with Stall = 0.
- Stall and reset together: reset wins; counter stays 0.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset then flow:
  - Stimulus: reset pulse; then A1D=2, A2D=3, A3D=4, resD=01, Stall=0, for 3 edges.
  - Required: E=(2,3,4,01) after edge 1; M=(4,01) after edge 2; W=(4,01) after edge 3; StallCnt=0.
- Load-use bubble:
  - Stimulus: D holds lw (A3D=5, resD=10); next cycle Stall=1 for 1 cycle.
  - Required: during the stall, PCEn=0, IFIDEn=0, IDEXClr=1; at the stall edge E becomes all zero with res_E=00, while M receives the lw tag (5,10); StallCnt=1.
- $0 sanitize:
  - Stimulus: A3D=0, resD=01, Stall=0.
  - Required: after 1 edge, A3E=0, res_E=00.
- Counter saturation:
  - Stimulus: CNT_W=3, hold Stall=1 for 10 edges.
  - Required: StallCnt reads 1..7, then stays at 7.
- Async reset mid-stream:
  - Stimulus: pipeline full (E/M/W all non-zero); assert reset between clock edges.
  - Required: all tags and StallCnt go to 0 before the next edge.
- Back-to-back stalls:
  - Stimulus: Stall=1 for 2 cycles, then 0, with D held at (6,7,8,01).
  - Required: two bubbles in E; E=(6,7,8,01) after the third edge; StallCnt=2.
